// File: rtl/lab3_g29_p5_pkg.sv
// rtl/lab3_g29_p5_pkg.sv - shared types and constants for the key encoder
package lab3_g29_p5_pkg;

   localparam int REQ_W  = 16;
   localparam int CODE_W = 4;
   localparam logic [REQ_W-1:0] ALL_IDLE = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      PRESENT,
      RELEASE
   } state_t;

endpackage

// File: rtl/lab3_g29_p5_prio_enc16.sv
// rtl/lab3_g29_p5_prio_enc16.sv - highest-index priority encoder for active-low requests
module lab3_g29_p5_prio_enc16
   import lab3_g29_p5_pkg::*;
(
   input  logic [REQ_W-1:0]  req_n,
   output logic [CODE_W-1:0] code_o,
   output logic              any_o,
   output logic              multi_o
);

   logic [4:0] zeros;

   // Ascending scan so the last (highest) active index overwrites lower ones.
   always_comb begin
      code_o = '0;
      zeros  = '0;
      for (int i = 0; i < REQ_W; i++) begin
         if (!req_n[i]) begin
            code_o = CODE_W'(i);
            zeros  = zeros + 5'd1;
         end
      end
      any_o   = (zeros != 5'd0);
      multi_o = (zeros > 5'd1);
   end

endmodule

// File: rtl/lab3_g29_p5_key_encoder.sv
// rtl/lab3_g29_p5_key_encoder.sv - synchronise, debounce and encode 16 active-low keys
module lab3_g29_p5_key_encoder
   import lab3_g29_p5_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REQ_W-1:0]  req_n,
   output logic [CODE_W-1:0] code_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              multi_o,
   output logic              busy_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][REQ_W-1:0] sync_q;
   logic [REQ_W-1:0]  sync;
   logic [REQ_W-1:0]  snap_q, snap_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_d, enc_code;
   logic              valid_d, multi_d, enc_any, enc_multi;

   assign sync = sync_q[SYNC_STAGES-1];

   lab3_g29_p5_prio_enc16 u_enc (
      .req_n   (snap_q),
      .code_o  (enc_code),
      .any_o   (enc_any),
      .multi_o (enc_multi)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= {SYNC_STAGES{ALL_IDLE}};
         snap_q  <= ALL_IDLE;
         cnt_q   <= '0;
         state_q <= IDLE;
         code_o  <= '0;
         valid_o <= 1'b0;
         multi_o <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], req_n};
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         code_o  <= code_d;
         valid_o <= valid_d;
         multi_o <= multi_d;
         busy_o  <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      code_d  = code_o;
      valid_d = valid_o;
      multi_d = multi_o;
      unique case (state_q)
         IDLE: begin
            if (sync != ALL_IDLE) begin
               snap_d  = sync;
               cnt_d   = CW'(1);
               state_d = ARM;
            end
         end
         ARM: begin
            if (sync == ALL_IDLE) begin
               state_d = IDLE;
            end else if (sync != snap_q) begin
               snap_d = sync;
               cnt_d  = CW'(1);
            end else if (cnt_q == CNT_LAST) begin
               code_d  = enc_code;
               multi_d = enc_multi & enc_any;
               valid_d = 1'b1;
               state_d = PRESENT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESENT: begin
            if (ready_i) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Any held line restarts the all-high count, so a held key never repeats.
            if (sync == ALL_IDLE) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) state_d = IDLE;
            end else begin
               cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lab3_g29_p5_key_encoder.sv
// tb/tb_lab3_g29_p5_key_encoder.sv - directed self-checking bench for the key encoder
module tb_lab3_g29_p5_key_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req_n;
   logic [3:0]  code_o;
   logic        valid_o;
   logic        ready_i;
   logic        multi_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   int pulses;

   lab3_g29_p5_key_encoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_n   (req_n),
      .code_o  (code_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .multi_o (multi_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_no_valid(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         step(1);
         check(tag, valid_o, 1'b0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      req_n   = 16'hFFFF;
      ready_i = 1'b0;
      step(3);
      check("rst_valid", valid_o, 1'b0);
      check("rst_code",  code_o,  4'd0);
      check("rst_multi", multi_o, 1'b0);
      check("rst_busy",  busy_o,  1'b0);
      rst_n = 1'b1;
      step(2);

      // Single key, bit 5: valid after edge 6
      req_n = 16'hFFDF;
      step(5);
      check("b5_early_valid", valid_o, 1'b0);
      step(1);
      check("b5_valid", valid_o, 1'b1);
      check("b5_code",  code_o,  4'd5);
      check("b5_multi", multi_o, 1'b0);
      check("b5_busy",  busy_o,  1'b1);
      ready_i = 1'b1;
      step(1);
      ready_i = 1'b0;
      check("b5_hs_valid", valid_o, 1'b0);
      check("b5_hs_busy",  busy_o,  1'b1);
      check("b5_hold_code", code_o, 4'd5);
      req_n = 16'hFFFF;
      step(5);
      check("b5_rel_busy_early", busy_o, 1'b1);
      step(1);
      check("b5_rel_busy", busy_o, 1'b0);
      check("b5_rel_code", code_o, 4'd5);

      // Two keys, bits 12 and 3
      req_n = 16'hEFF7;
      step(6);
      check("multi_valid", valid_o, 1'b1);
      check("multi_code",  code_o,  4'd12);
      check("multi_multi", multi_o, 1'b1);
      ready_i = 1'b1;
      step(1);
      ready_i = 1'b0;
      check("multi_hs_valid", valid_o, 1'b0);
      req_n = 16'hFFFF;
      step(6);
      check("multi_rel_busy", busy_o, 1'b0);

      // Bounce on bit 9: low 2, high 1, then low steady
      req_n = 16'hFDFF;
      step_no_valid(2, "bounce_a");
      req_n = 16'hFFFF;
      step_no_valid(1, "bounce_b");
      req_n = 16'hFDFF;
      step_no_valid(5, "bounce_c");
      step(1);
      check("bounce_valid", valid_o, 1'b1);
      check("bounce_code",  code_o,  4'd9);
      check("bounce_multi", multi_o, 1'b0);
      ready_i = 1'b1;
      step(1);
      ready_i = 1'b0;
      check("bounce_hs_valid", valid_o, 1'b0);
      req_n = 16'hFFFF;
      step(6);
      check("bounce_rel_busy", busy_o, 1'b0);

      // Backpressure: bit 11 captured, input moves to bit 2 while stalled
      req_n = 16'hF7FF;
      step(6);
      check("bp_valid", valid_o, 1'b1);
      check("bp_code",  code_o,  4'd11);
      req_n = 16'hFFFB;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("bp_hold_valid", valid_o, 1'b1);
         check("bp_hold_code",  code_o,  4'd11);
      end
      ready_i = 1'b1;
      step(1);
      check("bp_hs_valid", valid_o, 1'b0);
      step_no_valid(20, "bp_no_second");
      check("bp_keep_code", code_o, 4'd11);
      req_n = 16'hFFFF;
      step(6);
      check("bp_rel_busy", busy_o, 1'b0);

      // Bit 7 held 50 cycles with ready tied high: one pulse only
      req_n  = 16'hFF7F;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (valid_o === 1'b1) pulses++;
      end
      check("hold_pulses", 16'(pulses), 16'd1);
      check("hold_code",   code_o, 4'd7);
      req_n = 16'hFFFF;
      step(6);
      check("hold_rel_busy", busy_o, 1'b0);

      // Reset while presenting, then fresh capture with input still held
      ready_i = 1'b0;
      req_n   = 16'hFFF7;
      step(6);
      check("mid_valid", valid_o, 1'b1);
      check("mid_code",  code_o,  4'd3);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("mid_rst_valid", valid_o, 1'b0);
      check("mid_rst_code",  code_o,  4'd0);
      check("mid_rst_busy",  busy_o,  1'b0);
      check("mid_rst_multi", multi_o, 1'b0);
      step(5);
      check("mid_early_valid", valid_o, 1'b0);
      step(1);
      check("mid_recap_valid", valid_o, 1'b1);
      check("mid_recap_code",  code_o,  4'd3);
      ready_i = 1'b1;
      step(1);
      check("mid_hs_valid", valid_o, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
